// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Used by regfile_mp and regfile_init_seq.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest register supported by byte_merge; callers zero-extend narrower words.
  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

  // Address width for a given depth, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 2) ? unsigned'($clog2(depth)) : 32'd1;
  endfunction

  // Replace each byte of old_v whose enable is set with the matching byte of data_v.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] data_v,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_v;
    for (int unsigned b = 0; b < MAX_BE_W; b++) begin
      if (be[b]) r[b*8 +: 8] = data_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset init sequencer: walks every register address once, asking the
// array to clear it, then holds RUN (ready) until the next reset.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic              ready_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and clear-counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: one register cleared per cycle, leave INIT after the last one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_we_o = 1'b0;
    ready_o   = 1'b0;
    unique case (state_q)
      INIT: begin
        init_we_o = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        ready_o = 1'b1;
      end
      default: state_d = INIT;
    endcase
  end

  assign init_addr_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NUM_RD combinational read ports,
// two byte-enabled write ports (port 1 wins per byte on a same-address
// conflict), optional hard-wired zero register, self-clearing after reset.
// Optional write-through forwarding is compiled in with `define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = 32,
  parameter  int unsigned DEPTH    = 16,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned ZERO_REG = 0,
  localparam int unsigned ADDR_W   = addr_w(DEPTH),
  localparam int unsigned BE_W     = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic [BE_W-1:0]          wr0_be,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [BE_W-1:0]          wr1_be,
  output logic                     ready
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              ready_w;
  logic              wr0_ok, wr1_ok;
  logic [BE_W-1:0]   be0_eff, be1_eff;

  regfile_init_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .ready_o     (ready_w)
  );

  assign ready = ready_w;

  function automatic logic [DATA_W-1:0] merge_w(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] data_v,
    input logic [BE_W-1:0]   be
  );
    return DATA_W'(byte_merge(MAX_DATA_W'(old_v), MAX_DATA_W'(data_v), MAX_BE_W'(be)));
  endfunction

  // Writes count only in RUN and never land on a hard-wired zero register;
  // folding that into the byte enables lets writes and bypass share one path.
  assign wr0_ok  = ready_w & wr0_en & ~((ZERO_REG != 0) & (wr0_addr == '0));
  assign wr1_ok  = ready_w & wr1_en & ~((ZERO_REG != 0) & (wr1_addr == '0));
  assign be0_eff = wr0_ok ? wr0_be : '0;
  assign be1_eff = wr1_ok ? wr1_be : '0;

  // Next array contents: init clear, else port 0 merge then port 1 merge on top.
  always_comb begin
    for (int unsigned a = 0; a < DEPTH; a++) begin
      mem_d[a] = mem_q[a];
      if (init_we && (init_addr == ADDR_W'(a))) begin
        mem_d[a] = '0;
      end else begin
        if (wr0_addr == ADDR_W'(a)) mem_d[a] = merge_w(mem_d[a], wr0_data, be0_eff);
        if (wr1_addr == ADDR_W'(a)) mem_d[a] = merge_w(mem_d[a], wr1_data, be1_eff);
      end
    end
  end

  // Array storage; contents are defined by the init sweep, not by reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    // Read mux with optional forwarding, zeroed during INIT and for register 0.
    always_comb begin
      rv = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr0_addr == ra) rv = merge_w(rv, wr0_data, be0_eff);
      if (wr1_addr == ra) rv = merge_w(rv, wr1_data, be1_eff);
`endif
      if (!ready_w || ((ZERO_REG != 0) && (ra == '0))) rv = '0;
    end

    assign rd_data[i*DATA_W +: DATA_W] = rv;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the successor to the fixed 16x32 two-read/one-write register file.
- Adds N read ports, two write ports with byte enables and a defined write-write conflict rule.
- Optional hard-wired zero register.
- Self-clearing init sequencer, so contents are defined after reset.
- Sits in the datapath between decode (address sources) and the execute/writeback stages.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
DEPTH, 16, number of registers; power of two, at least 2.
NUM_RD, 2, number of read ports, 1..4.
ZERO_REG, 0, when 1, register 0 reads as zero and writes to it are dropped.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W].
rd_data  out  NUM_RD*DATA_W  packed read data; port i at [i*DATA_W +: DATA_W].
wr0_en  in  1  write port 0 enable.
wr0_addr  in  ADDR_W  write port 0 address.
wr0_data  in  DATA_W  write port 0 data.
wr0_be  in  DATA_W/8  write port 0 byte enables.
wr1_en, wr1_addr, wr1_data, wr1_be: same as port 0, for write port 1.
ready  out  1  high once init is complete and writes are accepted.

Behaviour:
- ADDR_W = $clog2(DEPTH).
- Reset (rst_n low, asynchronous):
  - FSM goes to INIT, init counter = 0, ready = 0.
  - rd_data is forced to 0 while in INIT.
  - Array contents are not reset directly.
- INIT state:
  - One register per cycle: mem[cnt] <= 0, cnt++.
  - After the cycle that writes DEPTH-1, go to RUN. Init takes exactly DEPTH cycles after rst_n rises; ready goes high at the next edge.
  - wr0/wr1 are ignored in INIT.
- RUN state:
  - ready = 1; the FSM stays in RUN until reset.
  - Writes: on the rising edge, if wrK_en, each byte b with wrK_be[b] = 1 is updated from wrK_data.
  - Byte enable all-zero with en = 1: no change.
- Write-write conflict (same address, both enabled): merge per byte. Port 1 wins on bytes both ports enable; bytes enabled by only one port take that port's data.
- Reads:
  - Combinational: rd_data[i] = mem[rd_addr[i]] (0 latency).
  - Read-during-write returns the old value unless bypass is compiled in (see Optional Feature).
- ZERO_REG = 1: reads of address 0 return 0 on every port; writes to address 0 are dropped, including via bypass.
- Reset asserted mid-init or mid-run: init restarts from 0; prior contents are cleared again by the new init.
- Any address in 0..DEPTH-1 is legal; there is no out-of-range case.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: a read whose address matches an enabled write in the same cycle (RUN only) returns the merged post-write value. Enabled bytes come from the write port(s), with port 1 taking priority; disabled bytes come from mem. This gives write-through forwarding with zero latency.
- Undefined: reads return the pre-edge mem value. The new value is visible the cycle after the write.

Decomposition:
- Package regfile_pkg holds:
  - FSM enum state_t {INIT, RUN};
  - function byte_merge(old, data, be);
  - function clog2-derived width helper.
- One sub-module, regfile_init_seq: counter plus FSM, producing init_we, init_addr and ready.
- The top module holds the array, the write merge logic and the read/bypass muxes.

Test Plan:
- Reset with DEPTH=16, then wait 15 cycles -> ready = 0. At cycle 16 -> ready = 1. All 16 registers read 0x00000000.
- Write addr 3 with 0xABCDE123, be = 4'hF; next cycle read rd_addr0 = 3 -> 0xABCDE123. rd_addr1 = 2 -> 0x00000000.
- Conflict on addr 5: port 0 writes 0x11111111 with be = 4'b0011, port 1 writes 0x22222222 with be = 4'b0110 -> mem[5] = 0x00222211.
- ZERO_REG = 1: write addr 0 with 0xFFFFFFFF -> reads of addr 0 return 0 on all ports, with or without the macro defined.
- Bypass: write addr 7 with 0xDEADBEEF while reading addr 7 in the same cycle.
  - REGFILE_BYPASS_EN defined -> 0xDEADBEEF in the same cycle.
  - Undefined -> old value 0x00000000, then 0xDEADBEEF the next cycle.
- Pull rst_n low at init count 8 after registers were written in RUN -> ready drops immediately. After release, 16 more cycles of init, then all registers read 0. Writes issued during INIT are dropped.
